// File: rtl/gelato_wb_arbiter.sv
// Write-back arbiter: round-robin selection of one execute-unit write-back per
// cycle into the warp register file, with a matching scoreboard release.

package gelato_wb_pkg;
    localparam int unsigned REG_NUM_W  = 5;
    localparam int unsigned WARP_NUM_W = 3;
    localparam int unsigned NUM_LANES  = 8;
    localparam int unsigned LANE_W     = 32;

    typedef logic [REG_NUM_W-1:0]        reg_num_t;
    typedef logic [WARP_NUM_W-1:0]       warp_num_t;
    typedef logic [NUM_LANES-1:0]        thread_mask_t;
    typedef logic [NUM_LANES*LANE_W-1:0] warp_reg_t;

    typedef struct packed {
        reg_num_t     reg_num;
        warp_num_t    warp_num;
        thread_mask_t thread_mask;
        warp_reg_t    data;
    } wb_req_t;
endpackage

module gelato_wb_arbiter
    import gelato_wb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic         [NUM_SRC-1:0]         src_valid,
    output logic         [NUM_SRC-1:0]         src_caught,
    input  reg_num_t     [NUM_SRC-1:0]         src_reg_num,
    input  warp_num_t    [NUM_SRC-1:0]         src_warp_num,
    input  thread_mask_t [NUM_SRC-1:0]         src_thread_mask,
    input  warp_reg_t    [NUM_SRC-1:0]         src_data,
    input  logic                               rf_stall,
    output logic                               rf_we,
    output reg_num_t                           rf_reg_num,
    output warp_num_t                          rf_warp_num,
    output thread_mask_t                       rf_thread_mask,
    output warp_reg_t                          rf_data,
    output logic                               sb_release,
    output warp_num_t                          sb_warp_num,
    output reg_num_t                           sb_reg_num,
    output logic         [31:0]                grant_cnt
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = 32;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    wb_req_t            out_q, out_d;
    logic               rf_we_q, rf_we_d;
    logic               sb_release_q, sb_release_d;
    logic [CNT_W-1:0]   grant_cnt_q, grant_cnt_d;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant_oh;
    logic [PTR_W:0]     cand;

    // Scan sources starting at rr_ptr and pick the first valid one, unless stalled
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_SRC)) begin
                cand = cand - (PTR_W+1)'(NUM_SRC);
            end
            if (!rf_stall && !grant_vld && src_valid[PTR_W'(cand)]) begin
                grant_vld                = 1'b1;
                grant_idx                = PTR_W'(cand);
                grant_oh[PTR_W'(cand)]   = 1'b1;
            end
        end
    end

    // Caught is combinational but must read as zero while reset is held
    assign src_caught = rst ? '0 : grant_oh;

    // Next-state: pointer advance, output capture, write suppression, grant count
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        out_d        = out_q;
        rf_we_d      = 1'b0;
        sb_release_d = 1'b0;
        grant_cnt_d  = grant_cnt_q;
        if (grant_vld) begin
            rr_ptr_d          = (grant_idx == PTR_W'(NUM_SRC-1)) ? '0 : grant_idx + PTR_W'(1);
            out_d.reg_num     = src_reg_num[grant_idx];
            out_d.warp_num    = src_warp_num[grant_idx];
            out_d.thread_mask = src_thread_mask[grant_idx];
            out_d.data        = src_data[grant_idx];
            // r0 is hard-wired and an empty mask writes nothing; release still fires
            rf_we_d           = (src_reg_num[grant_idx] != '0) && (src_thread_mask[grant_idx] != '0);
            sb_release_d      = 1'b1;
            grant_cnt_d       = grant_cnt_q + CNT_W'(1);
        end
    end

    // State and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            out_q        <= '0;
            rf_we_q      <= 1'b0;
            sb_release_q <= 1'b0;
            grant_cnt_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_q        <= out_d;
            rf_we_q      <= rf_we_d;
            sb_release_q <= sb_release_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_reg_num     = out_q.reg_num;
    assign rf_warp_num    = out_q.warp_num;
    assign rf_thread_mask = out_q.thread_mask;
    assign rf_data        = out_q.data;
    assign sb_release     = sb_release_q;
    assign sb_warp_num    = out_q.warp_num;
    assign sb_reg_num     = out_q.reg_num;
    assign grant_cnt      = grant_cnt_q;

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Scoreboard bench for gelato_wb_arbiter: stimulus pushes expected caught
// vectors and expected write-backs; a negedge monitor pops and compares.

module tb_gelato_wb_arbiter;
    import gelato_wb_pkg::*;

    localparam int unsigned NS = 4;

    logic                    clk;
    logic                    rst;
    logic         [NS-1:0]   src_valid;
    logic         [NS-1:0]   src_caught;
    reg_num_t     [NS-1:0]   src_reg_num;
    warp_num_t    [NS-1:0]   src_warp_num;
    thread_mask_t [NS-1:0]   src_thread_mask;
    warp_reg_t    [NS-1:0]   src_data;
    logic                    rf_stall;
    logic                    rf_we;
    reg_num_t                rf_reg_num;
    warp_num_t               rf_warp_num;
    thread_mask_t            rf_thread_mask;
    warp_reg_t               rf_data;
    logic                    sb_release;
    warp_num_t               sb_warp_num;
    reg_num_t                sb_reg_num;
    logic [31:0]             grant_cnt;

    gelato_wb_arbiter #(.NUM_SRC(NS)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_caught     (src_caught),
        .src_reg_num    (src_reg_num),
        .src_warp_num   (src_warp_num),
        .src_thread_mask(src_thread_mask),
        .src_data       (src_data),
        .rf_stall       (rf_stall),
        .rf_we          (rf_we),
        .rf_reg_num     (rf_reg_num),
        .rf_warp_num    (rf_warp_num),
        .rf_thread_mask (rf_thread_mask),
        .rf_data        (rf_data),
        .sb_release     (sb_release),
        .sb_warp_num    (sb_warp_num),
        .sb_reg_num     (sb_reg_num),
        .grant_cnt      (grant_cnt)
    );

    typedef struct {
        int           cyc;
        logic         we;
        reg_num_t     reg_num;
        warp_num_t    warp_num;
        thread_mask_t mask;
        warp_reg_t    data;
        logic [31:0]  cnt;
    } exp_wb_t;

    exp_wb_t         wq[$];
    logic [NS-1:0]   cq[$];
    int              tests  = 0;
    int              failed = 0;
    int              cyc    = 0;
    logic [31:0]     exp_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setp(input int s, input reg_num_t r, input warp_num_t w,
                        input thread_mask_t m, input warp_reg_t d);
        src_reg_num[s]     = r;
        src_warp_num[s]    = w;
        src_thread_mask[s] = m;
        src_data[s]        = d;
    endtask

    // Drive one cycle; g is the hand-computed granted source or -1 for none
    task automatic step(input logic [NS-1:0] v, input logic stall, input int g);
        exp_wb_t w;
        src_valid = v;
        rf_stall  = stall;
        cq.push_back((g >= 0) ? NS'(32'(1) << g) : '0);
        if (g >= 0) begin
            exp_cnt    = exp_cnt + 32'd1;
            w.cyc      = cyc;
            w.reg_num  = src_reg_num[g];
            w.warp_num = src_warp_num[g];
            w.mask     = src_thread_mask[g];
            w.data     = src_data[g];
            w.we       = (src_reg_num[g] != '0) && (src_thread_mask[g] != '0);
            w.cnt      = exp_cnt;
            wq.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare caught every cycle, and each release against the queue head
    always @(negedge clk) begin
        exp_wb_t w;
        logic [NS-1:0] ec;
        if (!rst) begin
            if (cq.size() > 0) begin
                ec = cq.pop_front();
                chk("src_caught", 256'(src_caught), 256'(ec));
            end
            if (sb_release) begin
                if (wq.size() == 0) begin
                    chk("spurious_release", 256'(sb_release), 256'(0));
                end else begin
                    w = wq.pop_front();
                    chk("latency",     256'(cyc),            256'(w.cyc + 1));
                    chk("rf_we",       256'(rf_we),          256'(w.we));
                    chk("rf_reg_num",  256'(rf_reg_num),     256'(w.reg_num));
                    chk("rf_warp_num", 256'(rf_warp_num),    256'(w.warp_num));
                    chk("rf_mask",     256'(rf_thread_mask), 256'(w.mask));
                    chk("rf_data",     256'(rf_data),        256'(w.data));
                    chk("sb_reg_num",  256'(sb_reg_num),     256'(w.reg_num));
                    chk("sb_warp_num", 256'(sb_warp_num),    256'(w.warp_num));
                    chk("grant_cnt",   256'(grant_cnt),      256'(w.cnt));
                end
            end else if (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                chk("missing_release", 256'(sb_release), 256'(1));
            end
            if (rf_we && !sb_release) chk("we_without_release", 256'(rf_we), 256'(0));
        end
    end

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        rf_stall  = 1'b0;
        for (int s = 0; s < NS; s++) setp(s, '0, '0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        // reset values
        chk("rst_rf_we",      256'(rf_we),      256'(0));
        chk("rst_sb_release", 256'(sb_release), 256'(0));
        chk("rst_grant_cnt",  256'(grant_cnt),  256'(0));
        chk("rst_caught",     256'(src_caught), 256'(0));
        chk("rst_rf_reg",     256'(rf_reg_num), 256'(0));
        chk("rst_rf_data",    256'(rf_data),    256'(0));
        rst = 1'b0;

        // single request from source 2
        setp(0, 5'd1,  3'd0, 8'hFF, 256'h1111);
        setp(1, 5'd2,  3'd1, 8'h0F, 256'h2222);
        setp(2, 5'd5,  3'd3, 8'hFF, 256'hA);
        setp(3, 5'd9,  3'd7, 8'hF0, 256'h4444);
        step(4'b0100, 1'b0, 2);                 // rr -> 3
        step(4'b0000, 1'b0, -1);
        chk("single_cnt", 256'(grant_cnt), 256'(1));

        // bring rr to 0, then fairness with all valid
        step(4'b1000, 1'b0, 3);                 // rr -> 0
        setp(0, 5'd10, 3'd2, 8'h01, {8{32'hDEAD_0000}});
        setp(1, 5'd11, 3'd4, 8'h80, {8{32'hBEEF_0001}});
        setp(2, 5'd12, 3'd5, 8'hAA, {8{32'hCAFE_0002}});
        setp(3, 5'd13, 3'd6, 8'h55, {8{32'hF00D_0003}});
        for (int k = 0; k < 8; k++) step(4'b1111, 1'b0, k % 4);
        step(4'b0000, 1'b0, -1);
        chk("fair_cnt", 256'(grant_cnt), 256'(10));

        // wrap-around from rr=3 with sources 3 and 0
        step(4'b0100, 1'b0, 2);                 // rr -> 3
        step(4'b1001, 1'b0, 3);                 // rr -> 0
        step(4'b0001, 1'b0, 0);                 // rr -> 1
        step(4'b0011, 1'b0, 1);                 // rr -> 2 (proves rr was 1)

        // stall: grant just before stall still issues; then 1, 2
        step(4'b0001, 1'b0, 0);                 // rr -> 1
        for (int k = 0; k < 3; k++) step(4'b0110, 1'b1, -1);
        step(4'b0110, 1'b0, 1);                 // rr -> 2
        step(4'b0100, 1'b0, 2);                 // rr -> 3
        step(4'b0000, 1'b0, -1);

        // suppression: reg 0, and empty mask
        setp(3, 5'd0, 3'd1, 8'hFF, 256'h77);
        step(4'b1000, 1'b0, 3);                 // rr -> 0
        setp(1, 5'd7, 3'd2, 8'h00, 256'h88);
        step(4'b0010, 1'b0, 1);                 // rr -> 2
        step(4'b0000, 1'b0, -1);
        step(4'b0000, 1'b0, -1);

        // async reset while a write is in flight
        setp(0, 5'd3, 3'd1, 8'hFF, 256'h99);
        setp(2, 5'd4, 3'd2, 8'hFF, 256'hBB);
        step(4'b0001, 1'b0, 0);                 // rr -> 1, rf_we now high
        chk("pre_rst_we", 256'(rf_we), 256'(1));
        src_valid = 4'b0101;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rf_we",      256'(rf_we),      256'(0));
        chk("midrst_sb_release", 256'(sb_release), 256'(0));
        chk("midrst_caught",     256'(src_caught), 256'(0));
        chk("midrst_grant_cnt",  256'(grant_cnt),  256'(0));
        wq.delete();
        cq.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b0101, 1'b0, 0);                 // rr reset to 0 -> lowest valid
        step(4'b0000, 1'b0, -1);
        step(4'b0000, 1'b0, -1);

        chk("wq_drained", 256'(wq.size()), 256'(0));
        chk("cq_drained", 256'(cq.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
